intf_channel: RTL and testbench

Parameterised single-bit signalling channel shared between a producer and one or more consumers, with a constant-returning query and light edge monitoring. Each instance carries a compile-time tag (`PARAM`) so that multiple instances can be told apart. One instance sits at each hierarchy point that needs a shared flag. Instances may live inside named or unnamed generate blocks, and inside either branch of a generate-if. Consumers read the flag with zero latency and can also use a registered copy, edge pulses and a saturating edge counter.

---
 rtl/intf_channel.sv | 59 +++++
 tb/tb_intf_channel.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/intf_channel.sv
// Shared single-bit flag channel: zero-latency combinational copy of the producer's
// value plus a registered copy, edge pulses and a saturating edge counter.
module intf_channel #(
   parameter int signed PARAM = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        val_in,
   output logic        val,
   output logic        val_q,
   output logic        rise,
   output logic        fall,
   output logic [15:0] edge_count,
   output logic [31:0] param_id,
   output logic [31:0] func_val
);

   localparam logic [15:0] COUNT_MAX = 16'hFFFF;

   logic        prev_q, prev_d;
   logic        rise_q, rise_d;
   logic        fall_q, fall_d;
   logic [15:0] count_q, count_d;

   // Pure wire path so consumers see the producer's value from time 0, independent of reset.
   assign val      = val_in;
   assign param_id = 32'(PARAM);
   assign func_val = 32'd5;

   always_comb begin
      prev_d  = val;
      rise_d  = val & ~prev_q;
      fall_d  = ~val & prev_q;
      count_d = count_q;
      if ((val != prev_q) && (count_q != COUNT_MAX)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         count_q <= 16'd0;
      end else begin
         prev_q  <= prev_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         count_q <= count_d;
      end
   end

   assign val_q      = prev_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign edge_count = count_q;

endmodule

// File: tb/tb_intf_channel.sv
// Directed bench for intf_channel: tie-off instances, generate-if selection,
// reset behaviour, edge pulses, glitch immunity and counter saturation.
module tb_intf_channel;

   logic        clk;
   logic        rst;
   logic        val_in;
   logic        val, val_q, rise, fall;
   logic [15:0] edge_count;
   logic [31:0] param_id, func_val;

   int checks;
   int errors;

   // main instance under directed stimulus
   intf_channel #(.PARAM(7)) u_dut (
      .clk(clk), .rst(rst), .val_in(val_in), .val(val), .val_q(val_q),
      .rise(rise), .fall(fall), .edge_count(edge_count),
      .param_id(param_id), .func_val(func_val)
   );

   // two tie-off instances sharing a tag
   logic        a_val, a_val_q, a_rise, a_fall;
   logic [15:0] a_cnt;
   logic [31:0] a_pid, a_fv;
   logic        b_val, b_val_q, b_rise, b_fall;
   logic [15:0] b_cnt;
   logic [31:0] b_pid, b_fv;

   intf_channel #(.PARAM(1)) u_a (
      .clk(clk), .rst(rst), .val_in(1'b0), .val(a_val), .val_q(a_val_q),
      .rise(a_rise), .fall(a_fall), .edge_count(a_cnt),
      .param_id(a_pid), .func_val(a_fv)
   );

   intf_channel #(.PARAM(1)) u_b (
      .clk(clk), .rst(rst), .val_in(1'b1), .val(b_val), .val_q(b_val_q),
      .rise(b_rise), .fall(b_fall), .edge_count(b_cnt),
      .param_id(b_pid), .func_val(b_fv)
   );

   // generate-if: only the PARAM=2 instance is elaborated
   localparam bit USE_SEL = 1'b1;
   logic        g_val, g_val_q, g_rise, g_fall;
   logic [15:0] g_cnt;
   logic [31:0] g_pid, g_fv;

   if (USE_SEL) begin : g_sel
      intf_channel #(.PARAM(2)) u_ch (
         .clk(clk), .rst(rst), .val_in(1'b1), .val(g_val), .val_q(g_val_q),
         .rise(g_rise), .fall(g_fall), .edge_count(g_cnt),
         .param_id(g_pid), .func_val(g_fv)
      );
   end else begin : g_unsel
      intf_channel #(.PARAM(3)) u_ch (
         .clk(clk), .rst(rst), .val_in(1'b1), .val(g_val), .val_q(g_val_q),
         .rise(g_rise), .fall(g_fall), .edge_count(g_cnt),
         .param_id(g_pid), .func_val(g_fv)
      );
   end

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one clock and settle away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic eq, input logic er,
                             input logic ef, input logic [15:0] ec);
      check({tag, "_val_q"}, 32'(val_q), 32'(eq));
      check({tag, "_rise"},  32'(rise),  32'(er));
      check({tag, "_fall"},  32'(fall),  32'(ef));
      check({tag, "_count"}, 32'(edge_count), 32'(ec));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      val_in = 1'b1;
      #1;

      // time-zero view of every instance
      check("a_val", 32'(a_val), 32'd0);
      check("a_pid", a_pid, 32'd1);
      check("a_fv",  a_fv,  32'd5);
      check("a_regs", {a_val_q, a_rise, a_fall, a_cnt}, 32'd0);
      check("b_val", 32'(b_val), 32'd1);
      check("b_pid", b_pid, 32'd1);
      check("b_fv",  b_fv,  32'd5);
      check("b_regs", {b_val_q, b_rise, b_fall, b_cnt}, 32'd0);
      check("g_val", 32'(g_val), 32'd1);
      check("g_pid", g_pid, 32'd2);
      check("g_fv",  g_fv,  32'd5);
      check("g_regs", {g_val_q, g_rise, g_fall, g_cnt}, 32'd0);
      check("dut_val", 32'(val), 32'd1);
      check("dut_pid", param_id, 32'd7);
      check("dut_fv",  func_val, 32'd5);
      check_regs("rst0", 1'b0, 1'b0, 1'b0, 16'd0);

      // reset held across edges keeps registered state clear
      tick();
      tick();
      check_regs("rst_hold", 1'b0, 1'b0, 1'b0, 16'd0);

      // release with val_in=1: first edge sees a rise
      rst = 1'b0;
      tick();
      check_regs("rel1", 1'b1, 1'b1, 1'b0, 16'd1);
      check("g_rel_cnt", 32'(g_cnt), 32'd1);
      check("b_rel_rise", 32'(b_rise), 32'd1);
      check("a_rel_cnt", 32'(a_cnt), 32'd0);
      tick();
      check_regs("rel2", 1'b1, 1'b0, 1'b0, 16'd1);

      // 1 -> 0 -> 1 on consecutive cycles
      val_in = 1'b0;
      check("comb_val", 32'(val), 32'd0);
      tick();
      check_regs("tog_fall", 1'b0, 1'b0, 1'b1, 16'd2);
      val_in = 1'b1;
      tick();
      check_regs("tog_rise", 1'b1, 1'b1, 1'b0, 16'd3);
      tick();
      check_regs("tog_hold", 1'b1, 1'b0, 1'b0, 16'd3);

      // four more toggles to reach 7
      val_in = 1'b0; tick();
      val_in = 1'b1; tick();
      val_in = 1'b0; tick();
      val_in = 1'b1; tick();
      check_regs("cnt7", 1'b1, 1'b1, 1'b0, 16'd7);

      // mid-cycle asynchronous reset clears at once
      rst = 1'b1;
      #1;
      check_regs("async_rst", 1'b0, 1'b0, 1'b0, 16'd0);
      check("async_rst_val", 32'(val), 32'd1);
      check("async_rst_fv", func_val, 32'd5);

      // counting resumes from zero
      val_in = 1'b0;
      #2;
      rst = 1'b0;
      tick();
      check_regs("resume0", 1'b0, 1'b0, 1'b0, 16'd0);
      val_in = 1'b1;
      tick();
      check_regs("resume1", 1'b1, 1'b1, 1'b0, 16'd1);

      // glitch between edges is invisible to registered logic
      tick();
      val_in = 1'b0; #1;
      val_in = 1'b1; #1;
      tick();
      check_regs("glitch", 1'b1, 1'b0, 1'b0, 16'd1);

      // saturation: 65540 toggles starting from count 1
      for (int i = 0; i < 65540; i++) begin
         val_in = ~val_in;
         tick();
         if (i == 65532) check("sat_fffe", 32'(edge_count), 32'h0000_FFFE);
         if (i == 65533) check("sat_ffff", 32'(edge_count), 32'h0000_FFFF);
      end
      check_regs("sat_end", 1'b1, 1'b1, 1'b0, 16'hFFFF);
      val_in = 1'b0;
      tick();
      check_regs("sat_more", 1'b0, 1'b0, 1'b1, 16'hFFFF);
      tick();
      check_regs("sat_idle", 1'b0, 1'b0, 1'b0, 16'hFFFF);

      rst = 1'b1;
      #1;
      check_regs("sat_rst", 1'b0, 1'b0, 1'b0, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
